bin_to_temporal_tx: RTL and testbench

//  Transmit side of the temporal (race-logic) link: converts a bank of binary values

---
 rtl/temporal_pkg.sv | 15 +
 rtl/temporal_pulse_gen.sv | 19 +
 rtl/bin_to_temporal_tx.sv | 77 +++++++
 tb/tb_bin_to_temporal_tx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// temporal_pkg: shared gamma-cycle defaults, value type and spike window predicate
package temporal_pkg;
    localparam int GAMMA_CYCLE_WIDTH = 16;
    localparam int PULSE_WIDTH = 8;
    localparam int VALUE_WIDTH = $clog2(GAMMA_CYCLE_WIDTH);

    typedef logic [VALUE_WIDTH-1:0] gamma_t;

    // Truncated at gcw-2 so every line is low in the last count of the gamma cycle
    function automatic logic in_window(input int v, input int c,
                                       input int gcw = GAMMA_CYCLE_WIDTH,
                                       input int pw = PULSE_WIDTH);
        return v <= c && c < v + pw && c <= gcw - 2;
    endfunction
endpackage

// File: rtl/temporal_pulse_gen.sv
// temporal_pulse_gen: registered per-channel spike for the value/count seen next cycle
module temporal_pulse_gen
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = temporal_pkg::GAMMA_CYCLE_WIDTH,
    parameter int PULSE_WIDTH = temporal_pkg::PULSE_WIDTH,
    parameter int VALUE_WIDTH = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                   aclk,
    input  logic                   grst,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   enable,
    input  logic [VALUE_WIDTH-1:0] gamma_count,
    output logic                   spike
);
    always_ff @(posedge aclk or posedge grst)
        if (grst) spike <= 1'b0;
        else spike <= enable && in_window(int'(value), int'(gamma_count), GAMMA_CYCLE_WIDTH, PULSE_WIDTH);
endmodule

// File: rtl/bin_to_temporal_tx.sv
// bin_to_temporal_tx: double-buffered binary-to-race-logic spike transmitter
module bin_to_temporal_tx
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = temporal_pkg::GAMMA_CYCLE_WIDTH,
    parameter int PULSE_WIDTH = temporal_pkg::PULSE_WIDTH,
    parameter int NUM_CHANNELS = 16,
    parameter int VALUE_WIDTH = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                                    aclk,
    input  logic                                    grst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_CHANNELS-1:0][VALUE_WIDTH-1:0] in_values,
    input  logic [NUM_CHANNELS-1:0]                 in_mask,
    output logic [VALUE_WIDTH-1:0]                  gamma_count,
    output logic                                    gamma_start,
    output logic [NUM_CHANNELS-1:0]                 spike_out,
    output logic                                    underrun,
    output logic                                    range_err
);
    localparam logic [VALUE_WIDTH-1:0] LAST = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    logic [NUM_CHANNELS-1:0][VALUE_WIDTH-1:0] shadow_val, active_val, act_val_nx;
    logic [NUM_CHANNELS-1:0] shadow_mask, active_mask, act_mask_nx, bad;
    logic shadow_full, xfer, wrap;
    logic [VALUE_WIDTH-1:0] count_nx;

    assign in_ready = !shadow_full;
    assign xfer = in_valid && in_ready;
    assign wrap = gamma_count == LAST;
    assign gamma_start = gamma_count == '0;
    assign count_nx = wrap ? '0 : gamma_count + 1'b1;
    // On the swap edge an empty shadow lets a same-cycle transfer bypass straight in
    assign act_val_nx = !wrap ? active_val : shadow_full ? shadow_val : in_values;
    assign act_mask_nx = !wrap ? active_mask : shadow_full ? shadow_mask : xfer ? in_mask : '0;

    always_ff @(posedge aclk or posedge grst)
        if (grst) begin
            gamma_count <= '0;
            shadow_full <= 1'b0;
            shadow_val <= '0;
            shadow_mask <= '0;
            active_val <= '0;
            active_mask <= '0;
            underrun <= 1'b0;
            range_err <= 1'b0;
        end else begin
            gamma_count <= count_nx;
            shadow_full <= wrap ? 1'b0 : shadow_full | xfer;
            if (xfer && !wrap) begin
                shadow_val <= in_values;
                shadow_mask <= in_mask;
            end
            active_val <= act_val_nx;
            active_mask <= act_mask_nx;
            underrun <= wrap && !shadow_full && !xfer;
            range_err <= range_err | (|bad);
        end

    // Pulse generators see next-state bank and count so spike_out lines up with gamma_count
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign bad[i] = act_mask_nx[i] && act_val_nx[i] >= LAST;
        temporal_pulse_gen #(
            .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH(PULSE_WIDTH),
            .VALUE_WIDTH(VALUE_WIDTH)
        ) u_pg (
            .aclk(aclk),
            .grst(grst),
            .value(act_val_nx[i]),
            .enable(act_mask_nx[i]),
            .gamma_count(count_nx),
            .spike(spike_out[i])
        );
    end
endmodule

// File: tb/tb_bin_to_temporal_tx.sv
// tb_bin_to_temporal_tx: directed checks of the temporal transmitter at default parameters
module tb_bin_to_temporal_tx;
    logic aclk = 1'b0, grst = 1'b1, in_valid = 1'b0;
    logic in_ready, gamma_start, underrun, range_err;
    logic [15:0][3:0] in_values = '0;
    logic [15:0] in_mask = '0, spike_out;
    logic [3:0] gamma_count;
    int n_cmp = 0, n_err = 0;

    logic [15:0][3:0] va, vb, vc, vd, ve, vf, vg, vh, vi, vz;
    logic [15:0] ma, mb, mc, md, me, mf, mg, mh, mi, mz;

    bin_to_temporal_tx dut (
        .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
        .in_values(in_values), .in_mask(in_mask), .gamma_count(gamma_count),
        .gamma_start(gamma_start), .spike_out(spike_out), .underrun(underrun),
        .range_err(range_err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sync_to(input logic [3:0] c);
        int k = 0;
        while (gamma_count !== c && k < 40) begin
            tick();
            k++;
        end
        chk("sync_count", 32'(gamma_count), 32'(c));
    endtask

    function automatic logic [15:0] exp_spk(input logic [15:0][3:0] v, input logic [15:0] m, input int c);
        logic [15:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = m[i] && int'(v[i]) <= c && c < int'(v[i]) + 8 && c <= 14;
        return r;
    endfunction

    // Starts at count 15 of the previous gamma cycle, ends at count 15 of this one
    task automatic run_gamma(input string tag, input logic [15:0][3:0] v, input logic [15:0] m,
                             input logic uexp, input logic nvalid,
                             input logic [15:0][3:0] nv, input logic [15:0] nm);
        for (int c = 0; c < 16; c++) begin
            tick();
            chk({tag, "_count"}, 32'(gamma_count), 32'(c));
            chk({tag, "_spike"}, 32'(spike_out), 32'(exp_spk(v, m, c)));
            chk({tag, "_start"}, 32'(gamma_start), 32'(c == 0));
            chk({tag, "_underrun"}, 32'(underrun), 32'(uexp && c == 0));
            if (c == 0) chk({tag, "_ready0"}, 32'(in_ready), 32'd1);
            if (c == 1 || c == 15) chk({tag, "_ready"}, 32'(in_ready), 32'(!nvalid));
            if (c == 0) begin
                in_valid = nvalid;
                in_values = nv;
                in_mask = nm;
            end
        end
    endtask

    initial begin
        va = '0; va[0] = 4'd3; ma = 16'h0001;
        vb = '0; vb[1] = 4'd12; mb = 16'h0002;
        vc = '0; vc[1] = 4'd0; mc = 16'h0002;
        vd = '0; vd[3] = 4'd7; vd[4] = 4'd14; vd[5] = 4'd1; vd[6] = 4'd9; vd[7] = 4'd2; md = 16'h0078;
        ve = '0; ve[2] = 4'd15; me = 16'h0004;
        vf = '0; vf[2] = 4'd5; mf = 16'h0000;
        for (int i = 0; i < 16; i++) vg[i] = 4'(i);
        mg = 16'hFFFF;
        vh = '0; vh[0] = 4'd2; vh[1] = 4'd4; mh = 16'h0003;
        vi = '0; vi[0] = 4'd5; mi = 16'h0001;
        vz = '0; mz = 16'h0000;

        #1;
        chk("rst_count", 32'(gamma_count), 32'd0);
        chk("rst_start", 32'(gamma_start), 32'd1);
        chk("rst_spike", 32'(spike_out), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_range", 32'(range_err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        #11;
        grst = 1'b0;

        in_valid = 1'b1; in_values = va; in_mask = ma;
        tick();
        chk("a_count1", 32'(gamma_count), 32'd1);
        chk("a_ready_drop", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        sync_to(4'd15);
        chk("a_silent_first", 32'(spike_out), 32'd0);
        run_gamma("a", va, ma, 1'b0, 1'b0, vz, mz);
        run_gamma("silent", vz, mz, 1'b1, 1'b0, vz, mz);

        in_valid = 1'b1; in_values = vb; in_mask = mb;
        run_gamma("b", vb, mb, 1'b0, 1'b1, vc, mc);
        run_gamma("c", vc, mc, 1'b0, 1'b1, vd, md);
        run_gamma("d", vd, md, 1'b0, 1'b1, ve, me);
        chk("range_clear", 32'(range_err), 32'd0);
        run_gamma("e", ve, me, 1'b0, 1'b1, vf, mf);
        chk("range_set", 32'(range_err), 32'd1);
        run_gamma("f", vf, mf, 1'b0, 1'b1, vg, mg);
        chk("range_sticky", 32'(range_err), 32'd1);
        run_gamma("g", vg, mg, 1'b0, 1'b1, vh, mh);
        in_valid = 1'b0;

        repeat (7) tick();
        chk("h_count6", 32'(gamma_count), 32'd6);
        chk("h_spike6", 32'(spike_out), 32'h0003);
        #1 grst = 1'b1;
        #1;
        chk("mid_rst_spike", 32'(spike_out), 32'd0);
        chk("mid_rst_count", 32'(gamma_count), 32'd0);
        chk("mid_rst_start", 32'(gamma_start), 32'd1);
        chk("mid_rst_range", 32'(range_err), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        #1 grst = 1'b0;
        in_valid = 1'b1; in_values = vi; in_mask = mi;
        tick();
        chk("i_count1", 32'(gamma_count), 32'd1);
        chk("i_ready_drop", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        for (int c = 1; c < 16; c++) begin
            if (c > 1) tick();
            chk("post_rst_count", 32'(gamma_count), 32'(c));
            chk("post_rst_spike", 32'(spike_out), 32'd0);
        end
        run_gamma("i", vi, mi, 1'b0, 1'b0, vz, mz);
        run_gamma("i_silent", vz, mz, 1'b1, 1'b0, vz, mz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
